rst_seq: RTL and testbench

- Parametrised, multi-channel successor to the single-output power-on reset generator.
- Stretches an asynchronous reset to a minimum length and waits for a clock-lock indication. Then releases NUM_CH reset domains one at a time, with a programmable gap between releases.
- Sits at the top of each FPGA/MPSoC clock domain, between the PLL/MMCM and the domain's logic. Also accepts a synchronous soft-reset request from the control plane.

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/rst_sync_bit.sv | 25 ++
 rtl/rst_seq.sv | 169 ++++++++++++++++
 tb/tb_rst_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, parameter
// defaults and a constant-evaluable ceil(log2) helper.
package rst_seq_pkg;

  localparam logic [1:0] ST_ASSERT    = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_PORF_LEN    = 10;
  localparam int DEF_STAGE_GAP   = 16;
  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_TIMEOUT_LEN = 65535;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rst_sync_bit.sv
// Multi-flop synchroniser with an asynchronous load of RST_VAL; used both as
// the reset-release chain (preset, fed 0) and as the lock synchroniser.
module rst_sync_bit #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Multi-channel reset sequencer: stretches reset, waits for lock, then releases
// channels 0..NUM_CH-1 one by one. Optional lock watchdog: RST_SEQ_LOCK_TIMEOUT_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int PORF_LEN    = DEF_PORF_LEN,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_LEN = DEF_TIMEOUT_LEN
) (
  input  logic              clk,
  input  logic              async_rst,
  input  logic              locked,
  input  logic              soft_rst,
  output logic [NUM_CH-1:0] sync_rst,
  output logic              rst_done,
  output logic              busy,
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  output logic              lock_timeout,
`endif
  output logic [1:0]        dbg_state
);

  localparam int CNT_MAX = (PORF_LEN > STAGE_GAP) ? PORF_LEN : STAGE_GAP;
  localparam int CNT_W   = clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PORF_LAST = CNT_W'(PORF_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  if (NUM_CH < 1 || NUM_CH > 16 || PORF_LEN < 2 || STAGE_GAP < 1 ||
      SYNC_STAGES < 2 || TIMEOUT_LEN < 1) begin : g_param_err
    $error("rst_seq: parameter out of range");
  end

  logic              w_int_rst;
  logic              w_locked_s;
  logic              w_restart;
  logic [NUM_CH-1:0] w_next_rst;
  logic              w_last_ch;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_sync_rst;

  rst_sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_int_rst_sync (
    .i_clk (clk),
    .i_rst (async_rst),
    .i_d   (1'b0),
    .o_q   (w_int_rst)
  );

  rst_sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .i_clk (clk),
    .i_rst (async_rst),
    .i_d   (locked),
    .o_q   (w_locked_s)
  );

  // Releasing by shifting in zeros from bit 0 makes the release order
  // monotonic by construction; the vector hitting zero marks the last channel.
  assign w_next_rst = r_sync_rst << 1;
  assign w_last_ch  = (w_next_rst == '0);
  assign w_restart  = soft_rst | ~w_locked_s;

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_LEN - 1);
  logic [31:0] r_wd_cnt;
  logic        r_lock_timeout;
`endif

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state    <= ST_ASSERT;
      r_cnt      <= '0;
      r_sync_rst <= '1;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
      r_wd_cnt       <= '0;
      r_lock_timeout <= 1'b0;
`endif
    end else begin
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
      r_lock_timeout <= 1'b0;
`endif
      if (w_int_rst) begin
        r_state    <= ST_ASSERT;
        r_cnt      <= '0;
        r_sync_rst <= '1;
      end else begin
        case (r_state)
          ST_ASSERT: begin
            r_sync_rst <= '1;
            if (soft_rst) begin
              r_cnt <= '0;
            end else if (r_cnt == PORF_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_WAIT_LOCK;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
              r_wd_cnt <= '0;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (soft_rst) begin
              r_cnt   <= '0;
              r_state <= ST_ASSERT;
            end else if (w_locked_s) begin
              // Channel 0 releases on the same edge that leaves WAIT_LOCK.
              r_cnt      <= '0;
              r_sync_rst <= w_next_rst;
              r_state    <= w_last_ch ? ST_DONE : ST_RELEASE;
            end
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
            else if (r_wd_cnt == WD_LAST) begin
              r_lock_timeout <= 1'b1;
              r_cnt          <= '0;
              r_state        <= ST_ASSERT;
            end else begin
              r_wd_cnt <= r_wd_cnt + 32'd1;
            end
`endif
          end
          ST_RELEASE: begin
            if (w_restart) begin
              r_cnt      <= '0;
              r_sync_rst <= '1;
              r_state    <= ST_ASSERT;
            end else if (r_cnt == GAP_LAST) begin
              r_cnt      <= '0;
              r_sync_rst <= w_next_rst;
              if (w_last_ch) r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_DONE: begin
            if (w_restart) begin
              r_cnt      <= '0;
              r_sync_rst <= '1;
              r_state    <= ST_ASSERT;
            end
          end
          default: begin
            r_cnt      <= '0;
            r_sync_rst <= '1;
            r_state    <= ST_ASSERT;
          end
        endcase
      end
    end
  end

  assign sync_rst  = r_sync_rst;
  assign rst_done  = (r_state == ST_DONE);
  assign busy      = (r_state != ST_DONE);
  assign dbg_state = r_state;

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  assign lock_timeout = r_lock_timeout;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with NUM_CH=3, PORF_LEN=10, STAGE_GAP=4, SYNC_STAGES=3.
module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam int N_CH = 3;

  logic            clk;
  logic            async_rst;
  logic            locked;
  logic            soft_rst;
  logic [N_CH-1:0] sync_rst;
  logic            rst_done;
  logic            busy;
  logic [1:0]      dbg_state;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  logic            lock_timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  rst_seq #(
    .NUM_CH      (N_CH),
    .PORF_LEN    (10),
    .STAGE_GAP   (4),
    .SYNC_STAGES (3),
    .TIMEOUT_LEN (20)
  ) dut (
    .clk          (clk),
    .async_rst    (async_rst),
    .locked       (locked),
    .soft_rst     (soft_rst),
    .sync_rst     (sync_rst),
    .rst_done     (rst_done),
    .busy         (busy),
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    .lock_timeout (lock_timeout),
`endif
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic soft_pulse();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
  endtask

  // {busy, rst_done, sync_rst} at e edges after the reference edge, given
  // channel 0 releasing at edge t0 and a gap of 4 edges per channel.
  function automatic logic [4:0] exp_vec(input int e, input int t0);
    if (e < t0)           return 5'b10_111;
    else if (e < t0 + 4)  return 5'b10_110;
    else if (e < t0 + 8)  return 5'b10_100;
    else                  return 5'b01_000;
  endfunction

  task automatic trace(input string tag, input int e_from, input int e_to,
                       input int t0, input int lock_up_at);
    for (int e = e_from; e <= e_to; e++) exp_q.push_back(exp_vec(e, t0));
    for (int e = e_from; e <= e_to; e++) begin
      tick();
      check($sformatf("%s_e%0d", tag, e), 32'({busy, rst_done, sync_rst}),
            32'(exp_q.pop_front()));
      if (e == lock_up_at) locked = 1'b1;
    end
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

  initial begin
    async_rst = 1'b0;
    locked    = 1'b1;
    soft_rst  = 1'b0;
    #1 async_rst = 1'b1;
    #1;
    check("por_async_outs", 32'({busy, rst_done, sync_rst}), 32'(5'b10_111));
    check("por_state", 32'(dbg_state), 32'(ST_ASSERT));
    repeat (3) @(posedge clk);
    @(negedge clk);
    async_rst = 1'b0;

    // power-on sequence: channels at edges 14, 18, 22
    trace("por", 1, 22, 14, -1);
    check("por_done_state", 32'(dbg_state), 32'(ST_DONE));
    repeat (3) tick();
    check("done_hold", 32'({busy, rst_done, sync_rst}), 32'(5'b01_000));

    // soft reset from DONE: release 11 edges later
    soft_pulse();
    check("soft_next", 32'({busy, rst_done, sync_rst}), 32'(5'b10_111));
    trace("soft", 1, 19, 11, -1);

    // lock loss between channel 0 and channel 1 release
    soft_pulse();
    trace("lk_pre", 1, 11, 11, -1);
    locked = 1'b0;
    for (int e = 12; e <= 14; e++) begin
      tick();
      check($sformatf("lk_hold_e%0d", e), 32'({busy, rst_done, sync_rst}),
            32'(5'b10_110));
    end
    tick();
    check("lk_restart", 32'({busy, rst_done, sync_rst}), 32'(5'b10_111));
    check("lk_restart_state", 32'(dbg_state), 32'(ST_ASSERT));

    // locked held low into WAIT_LOCK, raised after edge 20
    trace("lk_wait", 1, 15, 24, -1);
    check("lk_wait_state", 32'(dbg_state), 32'(ST_WAIT_LOCK));
    trace("lk_wait", 16, 32, 24, 20);

    // asynchronous reset in the middle of RELEASE
    soft_pulse();
    trace("ar_pre", 1, 12, 11, -1);
    @(posedge clk);
    #2 async_rst = 1'b1;
    #1;
    check("ar_async_outs", 32'({busy, rst_done, sync_rst}), 32'(5'b10_111));
    check("ar_state", 32'(dbg_state), 32'(ST_ASSERT));
    @(posedge clk);
    @(negedge clk);
    async_rst = 1'b0;
    trace("ar", 1, 22, 14, -1);

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    locked = 1'b0;
    soft_pulse();
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 29) check("wd_quiet", 32'(lock_timeout), 32'(0));
      if (e == 30) begin
        check("wd_pulse", 32'(lock_timeout), 32'(1));
        check("wd_state", 32'(dbg_state), 32'(ST_ASSERT));
      end
      if (e == 31) check("wd_single", 32'(lock_timeout), 32'(0));
    end
    check("wd_chans", 32'(sync_rst), 32'(3'b111));
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
